shift_pipe: RTL and testbench
=============================

SHIFT_PIPE -- requirements
Module: shift_pipe

Interface
REQ-001 SHALL have parameter N, default 32, data width; legal values are powers of two from 8 to 64.
REQ-002 SHALL have localparam S = $clog2(N), the shift-amount width and the pipeline depth.
REQ-003 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-005 SHALL have port flush, input, 1, synchronous clear of all in-flight operations.
REQ-006 SHALL have port in_valid, input, 1, request present.
REQ-007 SHALL have port in_ready, output, 1, request accepted when in_valid and in_ready are both high.
REQ-008 SHALL have port in_data, input, N, operand.
REQ-009 SHALL have port in_shamt, input, S, shift amount.
REQ-010 SHALL have port in_op, input, 2, shift_op_t: 00 SLL, 01 SRL, 10 SRA, 11 ROR.
REQ-011 SHALL have port out_valid, output, 1, result present.
REQ-012 SHALL have port out_ready, input, 1, result consumed when out_valid and out_ready are both high.
REQ-013 SHALL have port out_data, output, N, result.

Function
REQ-014 SHALL implement S cascaded log-shift levels; level k shifts by 2^k when shamt bit k is set, otherwise passes data through.
REQ-015 SHALL register each level's outputs: data, remaining shamt bits, op, and a valid bit.
REQ-016 SHALL have a fixed latency of S cycles from acceptance to out_valid when no stall occurs.
REQ-017 SHALL fill with zeros for SLL and SRL, with operand bit N-1 for SRA (captured at acceptance), and with wrapped low bits for ROR.
REQ-018 SHALL compute results bit-exact to the RV32I SLL, SRL and SRA instructions when N=32.
REQ-019 SHALL pass data through unchanged for shamt 0, in every op.
REQ-020 SHALL advance stage k when stage k is empty or stage k+1 advances; the last stage advances on out_ready.
REQ-021 SHALL drive in_ready high when stage 0 can advance; in_ready SHALL depend combinationally on out_ready.
REQ-022 SHALL sustain one operation per cycle when out_ready is held high.
REQ-023 SHALL hold a stalled stage's contents stable and keep out_data constant while out_valid is high and out_ready is low.
REQ-024 SHALL allow simultaneous accept and emit in the same cycle when all stages are full and out_ready is high.
REQ-025 SHALL clear all stage valid bits on flush, drive in_ready low in that cycle, and drop any in_valid presented in that cycle.
REQ-026 SHALL keep operations in order; no reordering or merging.

Reset
REQ-027 SHALL clear all stage valid bits asynchronously on rst_n low, forcing out_valid to 0.
REQ-028 SHALL clear data, shamt and op registers to 0 on reset, so out_data is 0.
REQ-029 SHALL drive in_ready low while rst_n is low and raise it in the first cycle after deassertion.
REQ-030 SHALL discard in-flight operations when reset is asserted mid-operation; none is emitted afterwards.

Structure
REQ-031 SHALL place the shift_op_t enum (SLL, SRL, SRA, ROR) in package shift_pkg.
REQ-032 SHALL implement each level as sub-module shift_stage, parameterised by N and a level index K, with one register slice per instance.
REQ-033 SHALL instantiate S shift_stage instances from a generate loop; no level is written out by hand.

Verification (N=32)
REQ-034 SHALL check SRA: 0x80000000, shamt 31 -> out_data 0xFFFFFFFF after 5 cycles.
REQ-035 SHALL check back-to-back ops with out_ready held high: SLL 0x1 by 4, SRL 0xF0 by 4, ROR 0x1 by 1 -> 0x10, 0xF, 0x80000000 on consecutive cycles.
REQ-036 SHALL check backpressure: out_ready low for 10 cycles with a continuous input stream -> exactly 5 accepted, in_ready low, out_data stable; releasing out_ready drains them in order.
REQ-037 SHALL check flush with 3 ops in flight -> out_valid never rises for those ops; the next op is emitted with latency 5.
REQ-038 SHALL check rst_n pulsed low mid-stream -> out_valid 0 and out_data 0 immediately, no stale outputs after release.
REQ-039 SHALL run a random regression of 10k ops with random out_ready against a reference model, covering all ops and shamt values 0..31.

Source files
------------

// File: rtl/shift_pkg.sv
// Shared types for the pipelined barrel shifter: operation encoding used by
// the top level and every shift level.
package shift_pkg;

  typedef enum logic [1:0] {
    SLL = 2'b00,
    SRL = 2'b01,
    SRA = 2'b10,
    ROR = 2'b11
  } shift_op_t;

endpackage

// File: rtl/shift_stage.sv
// One log-shifter level: shifts by 2**K when shamt bit K is set, then
// registers data, shamt, op, the SRA fill bit and a valid flag.
module shift_stage
  import shift_pkg::*;
#(
  parameter int N = 32,
  parameter int K = 0,
  localparam int S = $clog2(N)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            load,
  input  logic            in_valid,
  input  logic [N-1:0]    in_data,
  input  logic [S-1:0]    in_shamt,
  input  shift_op_t       in_op,
  input  logic            in_fill,
  output logic            out_valid,
  output logic [N-1:0]    out_data,
  output logic [S-1:0]    out_shamt,
  output shift_op_t       out_op,
  output logic            out_fill
);

  localparam int A = 1 << K;

  logic [N-1:0] shifted;
  logic [A-1:0] hi_bits;

  logic         valid_q, valid_d;
  logic [N-1:0] data_q,  data_d;
  logic [S-1:0] shamt_q, shamt_d;
  shift_op_t    op_q,    op_d;
  logic         fill_q,  fill_d;

  // Right shifts share one datapath; only the bits entering at the top differ.
  always_comb begin
    hi_bits = '0;
    case (in_op)
      SRA:     hi_bits = {A{in_fill}};
      ROR:     hi_bits = in_data[A-1:0];
      default: hi_bits = '0;
    endcase
    shifted = in_data;
    if (in_shamt[K]) begin
      if (in_op == SLL) begin
        shifted = {in_data[N-A-1:0], {A{1'b0}}};
      end else begin
        shifted = {hi_bits, in_data[N-1:A]};
      end
    end
  end

  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    shamt_d = shamt_q;
    op_d    = op_q;
    fill_d  = fill_q;
    if (flush) begin
      valid_d = 1'b0;
    end else if (load) begin
      valid_d = in_valid;
      if (in_valid) begin
        data_d  = shifted;
        shamt_d = in_shamt;
        op_d    = in_op;
        fill_d  = in_fill;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      shamt_q <= '0;
      op_q    <= SLL;
      fill_q  <= 1'b0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
      shamt_q <= shamt_d;
      op_q    <= op_d;
      fill_q  <= fill_d;
    end
  end

  assign out_valid = valid_q;
  assign out_data  = data_q;
  assign out_shamt = shamt_q;
  assign out_op    = op_q;
  assign out_fill  = fill_q;

endmodule

// File: rtl/shift_pipe.sv
// Pipelined barrel shifter (SLL/SRL/SRA/ROR), one log-shift level per stage,
// with valid/ready flow control, synchronous flush and async reset.
module shift_pipe
  import shift_pkg::*;
#(
  parameter int N = 32,
  localparam int S = $clog2(N)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          flush,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [N-1:0]  in_data,
  input  logic [S-1:0]  in_shamt,
  input  shift_op_t     in_op,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [N-1:0]  out_data
);

  // Index 0 is the accepted request; index k+1 is the register of stage k.
  logic         valid_a [0:S];
  logic [N-1:0] data_a  [0:S];
  logic [S-1:0] shamt_a [0:S];
  shift_op_t    op_a    [0:S];
  logic         fill_a  [0:S];
  logic [S:0]   adv;

  // A stage may load when its register is empty or its successor is loading.
  always_comb begin
    adv    = '0;
    adv[S] = out_ready;
    for (int k = S - 1; k >= 0; k--) begin
      adv[k] = ~valid_a[k+1] | adv[k+1];
    end
  end

  assign in_ready   = rst_n & ~flush & adv[0];
  assign valid_a[0] = in_valid & in_ready;
  assign data_a[0]  = in_data;
  assign shamt_a[0] = in_shamt;
  assign op_a[0]    = in_op;
  assign fill_a[0]  = in_data[N-1];

  genvar gi;
  generate
    for (gi = 0; gi < S; gi++) begin : g_stage
      shift_stage #(
        .N (N),
        .K (gi)
      ) u_stage (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .load      (adv[gi]),
        .in_valid  (valid_a[gi]),
        .in_data   (data_a[gi]),
        .in_shamt  (shamt_a[gi]),
        .in_op     (op_a[gi]),
        .in_fill   (fill_a[gi]),
        .out_valid (valid_a[gi+1]),
        .out_data  (data_a[gi+1]),
        .out_shamt (shamt_a[gi+1]),
        .out_op    (op_a[gi+1]),
        .out_fill  (fill_a[gi+1])
      );
    end
  endgenerate

  assign out_valid = valid_a[S];
  assign out_data  = data_a[S];

endmodule

// File: tb/tb_shift_pipe.sv
// Directed and randomized checks of shift_pipe at N=32.
module tb_shift_pipe;
  import shift_pkg::*;

  localparam int N = 32;
  localparam int S = 5;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          flush;
  logic          in_valid;
  logic          in_ready;
  logic [N-1:0]  in_data;
  logic [S-1:0]  in_shamt;
  shift_op_t     in_op;
  logic          out_valid;
  logic          out_ready;
  logic [N-1:0]  out_data;

  int n_cmp = 0;
  int n_bad = 0;
  logic [N-1:0] exp_q [$];

  shift_pipe #(.N(N)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_shamt  (in_shamt),
    .in_op     (in_op),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [N-1:0] obs, input logic [N-1:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input shift_op_t op, input logic [N-1:0] d, input logic [S-1:0] sh);
    in_valid = v;
    in_op    = op;
    in_data  = d;
    in_shamt = sh;
  endtask

  function automatic logic [N-1:0] ref_shift(input shift_op_t op, input logic [N-1:0] d, input logic [S-1:0] sh);
    logic [2*N-1:0] dbl;
    logic [N-1:0]   r;
    dbl = {d, d} >> sh;
    case (op)
      SLL:     r = d << sh;
      SRL:     r = d >> sh;
      SRA:     r = $signed(d) >>> sh;
      default: r = dbl[N-1:0];
    endcase
    return r;
  endfunction

  initial begin
    int acc;
    int cyc;
    rst_n = 1'b0;
    flush = 1'b0;
    out_ready = 1'b1;
    drive(1'b0, SLL, '0, '0);

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst_out_valid", N'(out_valid), 0);
    check("rst_out_data", out_data, 0);
    check("rst_in_ready", N'(in_ready), 0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("rst_release_in_ready", N'(in_ready), 1);
    step();
    $display("reset: done");

    // SRA of the sign bit by 31, latency 5
    drive(1'b1, SRA, 32'h8000_0000, 5'd31);
    #1;
    check("sra_in_ready", N'(in_ready), 1);
    step();
    in_valid = 1'b0;
    for (int k = 2; k <= 5; k++) begin
      check("sra_early_valid", N'(out_valid), 0);
      step();
    end
    check("sra_valid", N'(out_valid), 1);
    check("sra_data", out_data, 32'hFFFF_FFFF);
    step();
    check("sra_consumed", N'(out_valid), 0);
    $display("sra 0x80000000 >>> 31: out=%h", 32'hFFFF_FFFF);

    // Back-to-back with out_ready high
    drive(1'b1, SLL, 32'h1, 5'd4);  step();
    drive(1'b1, SRL, 32'hF0, 5'd4); step();
    drive(1'b1, ROR, 32'h1, 5'd1);  step();
    in_valid = 1'b0;
    step(); step();
    check("b2b_v0", N'(out_valid), 1);
    check("b2b_sll", out_data, 32'h10);
    step();
    check("b2b_v1", N'(out_valid), 1);
    check("b2b_srl", out_data, 32'hF);
    step();
    check("b2b_v2", N'(out_valid), 1);
    check("b2b_ror", out_data, 32'h8000_0000);
    step();
    check("b2b_empty", N'(out_valid), 0);
    $display("back-to-back: 3 results checked");

    // Backpressure: stream for 10 cycles with out_ready low, shamt 0 on every op
    out_ready = 1'b0;
    acc = 0;
    for (int i = 0; i < 10; i++) begin
      drive(1'b1, shift_op_t'(2'(i)), 32'hA000_0000 + N'(i), 5'd0);
      #1;
      if (i >= 5) check("bp_stable", out_data, 32'hA000_0000);
      if (in_ready) begin
        acc++;
        exp_q.push_back(in_data);
      end
      step();
    end
    in_valid = 1'b0;
    check("bp_accepted", N'(acc), 5);
    check("bp_in_ready", N'(in_ready), 0);
    check("bp_out_valid", N'(out_valid), 1);
    out_ready = 1'b1;
    for (int j = 0; j < 5; j++) begin
      #1;
      check("bp_drain_valid", N'(out_valid), 1);
      if (exp_q.size() > 0) check("bp_drain_data", out_data, exp_q.pop_front());
      step();
    end
    check("bp_drained", N'(out_valid), 0);
    $display("backpressure: %0d accepted, drained in order", acc);

    // Flush with 3 ops in flight
    drive(1'b1, SLL, 32'h5, 5'd1);       step();
    check("fl_v0", N'(out_valid), 0);
    drive(1'b1, SRL, 32'hFF00, 5'd8);    step();
    check("fl_v1", N'(out_valid), 0);
    drive(1'b1, SRA, 32'hF000_0000, 5'd2); step();
    check("fl_v2", N'(out_valid), 0);
    flush = 1'b1;
    drive(1'b1, SLL, 32'hDEAD, 5'd0);
    #1;
    check("fl_in_ready", N'(in_ready), 0);
    step();
    flush = 1'b0;
    in_valid = 1'b0;
    for (int k = 0; k < 8; k++) begin
      check("fl_no_output", N'(out_valid), 0);
      step();
    end
    drive(1'b1, SLL, 32'h3, 5'd2);
    step();
    in_valid = 1'b0;
    for (int k = 2; k <= 5; k++) begin
      check("fl_next_early", N'(out_valid), 0);
      step();
    end
    check("fl_next_valid", N'(out_valid), 1);
    check("fl_next_data", out_data, 32'hC);
    step();
    $display("flush: 3 ops dropped, next op out=%h", 32'hC);

    // Reset asserted while results are held at the output
    out_ready = 1'b0;
    drive(1'b1, ROR, 32'h1, 5'd8); step();
    drive(1'b1, SLL, 32'h1, 5'd1); step();
    in_valid = 1'b0;
    step(); step(); step();
    check("mr_valid_before", N'(out_valid), 1);
    check("mr_data_before", out_data, 32'h0100_0000);
    rst_n = 1'b0;
    #1;
    check("mr_valid", N'(out_valid), 0);
    check("mr_data", out_data, 0);
    check("mr_in_ready", N'(in_ready), 0);
    @(negedge clk);
    rst_n = 1'b1;
    out_ready = 1'b1;
    step();
    for (int k = 0; k < 8; k++) begin
      check("mr_no_stale", N'(out_valid), 0);
      step();
    end
    $display("mid-stream reset: outputs cleared");

    // Random regression against the reference model
    exp_q.delete();
    acc = 0;
    cyc = 0;
    while (acc < 10000 && cyc < 60000) begin
      @(negedge clk);
      cyc++;
      out_ready = ($urandom_range(0, 9) < 7);
      in_valid  = ($urandom_range(0, 3) != 0);
      case ($urandom_range(0, 3))
        0:       in_data = 32'h8000_0000;
        1:       in_data = 32'hFFFF_FFFF;
        default: in_data = $urandom;
      endcase
      in_shamt = 5'($urandom_range(0, 31));
      in_op    = shift_op_t'(2'($urandom_range(0, 3)));
      #1;
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $error("FAIL rnd_spurious: observed=%h expected=none", out_data);
        end else begin
          check("rnd_data", out_data, exp_q.pop_front());
        end
      end
      if (in_valid && in_ready) begin
        exp_q.push_back(ref_shift(in_op, in_data, in_shamt));
        acc++;
      end
    end
    @(negedge clk);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int k = 0; k < 40; k++) begin
      #1;
      if (out_valid) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $error("FAIL rnd_spurious: observed=%h expected=none", out_data);
        end else begin
          check("rnd_data", out_data, exp_q.pop_front());
        end
      end
      @(negedge clk);
    end
    check("rnd_accepted", N'(acc), 10000);
    check("rnd_leftover", N'(exp_q.size()), 0);
    $display("random: %0d ops in %0d cycles", acc, cyc);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
